hex_display_arbiter: RTL and testbench
======================================

# hex_display_arbiter

Shares the board's six seven-segment displays (hex0..hex5) between two requesters, such as the CPU memory-mapped port and a debug/monitor source. Each requester writes a 24-bit value (six hex nibbles) plus six decimal-point bits through a req/gnt handshake. The block arbitrates round-robin with a configurable ownership hold time, stores the winning value, and drives registered, active-low segment outputs. It sits between the core logic and the hex pins in the board top.

## Interface

Parameters:
- HOLD_CYCLES, default 50_000_000: cycles a new owner keeps exclusive access after each accepted write (1 s at 50 MHz); 0 means pure round-robin with no hold.

Ports:
- clk  input  1  system clock (max10_clk1_50 domain)
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 write request
- data0  input  24  requester 0 nibbles; [3:0] goes to hex0, [23:20] to hex5
- dp0  input  6  requester 0 decimal points; bit i = 1 lights dp of hex i
- gnt0  output  1  one-cycle pulse: requester 0 write accepted
- req1, data1, dp1, gnt1: same as requester 0, for requester 1
- owner  output  1  current owner, the last accepted requester
- hold_active  output  1  high while the hold counter is non-zero
- hex0..hex5  output  8 each  segments, active-low; bit 7 = dp, bits 6:0 = g..a

## Operation

- State: display register (24 data bits + 6 dp bits), valid flag, owner, hold counter of width $clog2(HOLD_CYCLES+1) (minimum 1 bit).
- Acceptance is evaluated at each rising edge. No write is accepted in a cycle where gnt0 or gnt1 is high, so each transfer takes at least 2 cycles.
- Hold counter non-zero: only the owner's req may be accepted. The other requester stalls with gnt low and must keep req, data and dp stable.
- Hold counter zero, one requester active: that requester wins.
- Hold counter zero, both active: the winner is the requester other than owner.
- On accept of requester i:
  - data and dp are captured into the display register.
  - valid is set to 1 and owner is set to i.
  - The counter loads HOLD_CYCLES.
  - gnt_i is asserted for exactly one cycle.
- An owner write during its own hold is accepted and reloads the counter.
- Counter behaviour: it decrements by 1 per cycle while non-zero and saturates at 0.
- Requester rule: sample gnt high, then drop req or present the next value. A req still held in the cycle after gnt counts as a new request.
- Segment encoding, bit 7 = 1, dp off:
  - 0:c0, 1:f9, 2:a4, 3:b0, 4:99, 5:92, 6:82, 7:f8
  - 8:80, 9:90, A:88, b:83, C:c6, d:a1, E:86, F:8e
- A lit dp clears bit 7.
- While valid = 0, all hex outputs are 8'hff (blank).

## Timing

- Reset values: gnt0 = gnt1 = 0; owner = 1, so requester 0 wins the first tie; hold counter = 0; hold_active = 0; valid = 0; display register = 0; hex0..hex5 = 8'hff.
- Accept at edge E: gnt_i, owner and hold_active change at E.
- The hex outputs show the new value after edge E+1 (one registered decode stage).
- hold_active falls at the edge where the counter reaches 0. A waiting requester can then be accepted at the next edge.
- Reset asserted mid-hold or mid-handshake: all state returns to reset values immediately and any pending request must be re-presented.

## Configuration

- HEX_BLANK_LEADING_EN defined: a digit is blanked (8'hff, dp also off) when it and every higher digit are zero. hex0 is never blanked. A lit dp on a digit forces that digit and all lower digits to be displayed.
- HEX_BLANK_LEADING_EN undefined: all six digits are always displayed once valid = 1.

## Structure

- Package hex_display_pkg holds:
  - the segment lookup constant (16 x 7 bits)
  - the blank constant 8'hff
  - NUM_DIGITS = 6
  - the requester index typedef (owner_t: REQ0, REQ1)
- Sub-module hex_seg_decoder converts one nibble + dp + blank into 8 active-low segment bits. It is combinational and instantiated six times; the top registers the results.

## Test plan

- Reset, then idle 5 cycles -> hex0..hex5 = 8'hff, gnt0 = gnt1 = 0, owner = 1, hold_active = 0.
- HOLD_CYCLES = 4; req0 with data0 = 24'h012345, dp0 = 0 -> one-cycle gnt0; one cycle later hex0 = 8'h92, hex1 = 8'h99, hex5 = 8'hc0 (or 8'hff with HEX_BLANK_LEADING_EN).
- HOLD_CYCLES = 4; req1 raised the cycle after gnt0 -> gnt1 stays low for 4 cycles, pulses on the edge after hold_active falls, owner becomes 1.
- HOLD_CYCLES = 0; req0 and req1 held high simultaneously from reset -> gnts alternate gnt0, gnt1, gnt0, ... each separated by at least one idle cycle.
- dp1 = 6'b000001, data1 = 24'hFFFFFF -> hex0 = 8'h0e, hex1..hex5 = 8'h8e.
- Reset pulsed while hold_active = 1 -> hold_active = 0 and hex outputs = 8'hff immediately; the next req1 is accepted without waiting.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants and types for the hex display arbiter: segment table,
// blank code, digit count and requester index.
package hex_display_pkg;

    localparam int NUM_DIGITS = 6;
    localparam logic [7:0] HEX_BLANK = 8'hff;

    // Active-low g..a patterns for nibble values 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
    };

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } owner_t;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble-to-segment decoder for one digit; active-low output,
// bit 7 is the decimal point.
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    assign seg = blank ? HEX_BLANK : {~dp, SEG_LUT[nibble]};

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing six seven-segment displays between two requesters,
// with an ownership hold timer. Optional macro: HEX_BLANK_LEADING_EN.
module hex_display_arbiter
    import hex_display_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [23:0] data0,
    input  logic [5:0]  dp0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [23:0] data1,
    input  logic [5:0]  dp1,
    output logic        gnt1,
    output logic        owner,
    output logic        hold_active,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic [7:0]  hex4,
    output logic [7:0]  hex5
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [23:0]           disp_data;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic                  valid_q;
    owner_t                owner_q;
    logic [CNT_W-1:0]      hold_cnt;
    logic                  gnt0_q;
    logic                  gnt1_q;
    logic                  acc0;
    logic                  acc1;

    always_comb begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        // A grant cycle blocks acceptance so every transfer spans two edges.
        if (!(gnt0_q || gnt1_q)) begin
            if (hold_cnt != '0) begin
                acc0 = req0 && (owner_q == REQ0);
                acc1 = req1 && (owner_q == REQ1);
            end else if (req0 && req1) begin
                acc0 = (owner_q == REQ1);
                acc1 = (owner_q == REQ0);
            end else begin
                acc0 = req0;
                acc1 = req1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_data <= '0;
            disp_dp   <= '0;
            valid_q   <= 1'b0;
            owner_q   <= REQ1;
            hold_cnt  <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
        end else begin
            gnt0_q <= acc0;
            gnt1_q <= acc1;
            if (acc0 || acc1) begin
                disp_data <= acc1 ? data1 : data0;
                disp_dp   <= acc1 ? dp1 : dp0;
                valid_q   <= 1'b1;
                owner_q   <= acc1 ? REQ1 : REQ0;
                hold_cnt  <= HOLD_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CNT_ONE;
            end
        end
    end

    logic [NUM_DIGITS-1:0] blank_lead;
    logic [NUM_DIGITS-1:0] blank_dig;

`ifdef HEX_BLANK_LEADING_EN
    logic lead_zero;

    // Walk down from the top digit; a lit dp ends the leading-zero run.
    always_comb begin
        blank_lead = '0;
        lead_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero     = lead_zero && (disp_data[4*i +: 4] == 4'h0) && !disp_dp[i];
            blank_lead[i] = lead_zero;
        end
    end
`else
    assign blank_lead = '0;
`endif

    assign blank_dig = blank_lead | {NUM_DIGITS{~valid_q}};

    logic [7:0] seg_w [NUM_DIGITS];
    logic [7:0] hex_q [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex_seg_decoder u_dec (
            .nibble (disp_data[4*g +: 4]),
            .dp     (disp_dp[g]),
            .blank  (blank_dig[g]),
            .seg    (seg_w[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= HEX_BLANK;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= seg_w[i];
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign owner       = owner_q;
    assign hold_active = (hold_cnt != '0);
    assign hex0        = hex_q[0];
    assign hex1        = hex_q[1];
    assign hex2        = hex_q[2];
    assign hex3        = hex_q[3];
    assign hex4        = hex_q[4];
    assign hex5        = hex_q[5];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: two instances (hold 4 and hold 0) checked every
// cycle against a behavioural model, plus directed literal checks.
module tb_hex_display_arbiter;

    logic clk = 1'b0;
    logic reset;

    logic [1:0][1:0]       req_v;
    logic [1:0][1:0][23:0] data_v;
    logic [1:0][1:0][5:0]  dp_v;
    logic [1:0][1:0]       gnt_w;
    logic [1:0]            owner_w;
    logic [1:0]            hold_w;
    logic [1:0][5:0][7:0]  hex_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hex_display_arbiter #(.HOLD_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req_v[0][0]), .data0(data_v[0][0]), .dp0(dp_v[0][0]), .gnt0(gnt_w[0][0]),
        .req1(req_v[0][1]), .data1(data_v[0][1]), .dp1(dp_v[0][1]), .gnt1(gnt_w[0][1]),
        .owner(owner_w[0]), .hold_active(hold_w[0]),
        .hex0(hex_w[0][0]), .hex1(hex_w[0][1]), .hex2(hex_w[0][2]),
        .hex3(hex_w[0][3]), .hex4(hex_w[0][4]), .hex5(hex_w[0][5])
    );

    hex_display_arbiter #(.HOLD_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req_v[1][0]), .data0(data_v[1][0]), .dp0(dp_v[1][0]), .gnt0(gnt_w[1][0]),
        .req1(req_v[1][1]), .data1(data_v[1][1]), .dp1(dp_v[1][1]), .gnt1(gnt_w[1][1]),
        .owner(owner_w[1]), .hold_active(hold_w[1]),
        .hex0(hex_w[1][0]), .hex1(hex_w[1][1]), .hex2(hex_w[1][2]),
        .hex3(hex_w[1][3]), .hex4(hex_w[1][4]), .hex5(hex_w[1][5])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_cnt   [2];
    bit         m_valid [2];
    logic [23:0] m_data [2];
    logic [5:0] m_dp    [2];
    int         m_owner [2];
    bit         m_gnt   [2][2];
    logic [7:0] m_hex   [2][6];

    function automatic int hold_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hc0; 4'h1: return 8'hf9; 4'h2: return 8'ha4; 4'h3: return 8'hb0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hf8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'ha: return 8'h88; 4'hb: return 8'h83;
            4'hc: return 8'hc6; 4'hd: return 8'ha1; 4'he: return 8'h86; default: return 8'h8e;
        endcase
    endfunction

    function automatic logic [7:0] exp_hex(input logic [23:0] d, input logic [5:0] p,
                                           input bit v, input int i);
        logic [7:0] s;
        if (!v) return 8'hff;
`ifdef HEX_BLANK_LEADING_EN
        if (i > 0 && (d >> (4 * i)) == 24'h0 && (p >> i) == 6'h0) return 8'hff;
`endif
        s = seg_of(d[4*i +: 4]);
        if (p[i]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_valid[k] = 0; m_data[k] = '0; m_dp[k] = '0; m_owner[k] = 1;
            m_gnt[k][0] = 0; m_gnt[k][1] = 0;
            for (int i = 0; i < 6; i++) m_hex[k][i] = 8'hff;
        end
    endtask

    task automatic model_step();
        int win;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) m_hex[k][i] = exp_hex(m_data[k], m_dp[k], m_valid[k], i);
            win = -1;
            if (!(m_gnt[k][0] || m_gnt[k][1])) begin
                if (m_cnt[k] > 0) begin
                    if (req_v[k][m_owner[k]]) win = m_owner[k];
                end else if (req_v[k][0] && req_v[k][1]) win = 1 - m_owner[k];
                else if (req_v[k][0]) win = 0;
                else if (req_v[k][1]) win = 1;
            end
            m_gnt[k][0] = (win == 0);
            m_gnt[k][1] = (win == 1);
            if (win >= 0) begin
                m_data[k]  = data_v[k][win];
                m_dp[k]    = dp_v[k][win];
                m_valid[k] = 1;
                m_owner[k] = win;
                m_cnt[k]   = hold_of(k);
            end else if (m_cnt[k] > 0) begin
                m_cnt[k]--;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    task automatic check_model(input int k);
        logic [51:0] act, exp;
        logic [5:0][7:0] eh;
        for (int i = 0; i < 6; i++) eh[i] = m_hex[k][i];
        act = {gnt_w[k][1], gnt_w[k][0], owner_w[k], hold_w[k], hex_w[k]};
        exp = {m_gnt[k][1], m_gnt[k][0], 1'(m_owner[k]), m_cnt[k] != 0, eh};
        chk($sformatf("model_dut%0d", k), 64'(act), 64'(exp));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check_model(0);
                check_model(1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic new_value(input int k, input int r);
        logic [31:0] d;
        d = $urandom >> ($urandom_range(0, 6) * 4);
        data_v[k][r] = d[23:0];
        dp_v[k][r]   = $urandom_range(0, 1) ? 6'h0 : 6'($urandom);
    endtask

    task automatic rand_req(input int k, input int r);
        if (req_v[k][r]) begin
            if (gnt_w[k][r]) begin
                if ($urandom_range(0, 1) == 1) req_v[k][r] = 1'b0;
                else new_value(k, r);
            end
        end else if ($urandom_range(0, 3) == 0) begin
            req_v[k][r] = 1'b1;
            new_value(k, r);
        end
    endtask

    logic [1:0] rr_exp [8];
    int n_wait;

    initial begin
        rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        reset  = 1'b1;
        req_v  = '0;
        data_v = '0;
        dp_v   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_hex", 64'(hex_w[k]), 64'({6{8'hff}}));
            chk("reset_gnt", 64'(gnt_w[k]), 64'h0);
            chk("reset_owner", 64'(owner_w[k]), 64'h1);
            chk("reset_hold", 64'(hold_w[k]), 64'h0);
        end

        // Hold 4: requester 0 write, then requester 1 waits out the hold
        req_v[0][0] = 1'b1; data_v[0][0] = 24'h012345; dp_v[0][0] = 6'h0;
        @(negedge clk);
        chk("gnt0_pulse", 64'(gnt_w[0][0]), 64'h1);
        chk("owner0", 64'(owner_w[0]), 64'h0);
        req_v[0][0] = 1'b0;
        req_v[0][1] = 1'b1; data_v[0][1] = 24'hffffff; dp_v[0][1] = 6'b000001;
        @(negedge clk);
        chk("gnt0_one_cycle", 64'(gnt_w[0][0]), 64'h0);
        chk("hex0_5", 64'(hex_w[0][0]), 64'h92);
        chk("hex1_4", 64'(hex_w[0][1]), 64'h99);
`ifdef HEX_BLANK_LEADING_EN
        chk("hex5_0", 64'(hex_w[0][5]), 64'hff);
`else
        chk("hex5_0", 64'(hex_w[0][5]), 64'hc0);
`endif
        n_wait = 1;
        while (!gnt_w[0][1] && n_wait < 20) begin
            @(negedge clk);
            if (!gnt_w[0][1]) n_wait++;
        end
        chk("gnt1_wait_cycles", 64'(n_wait), 64'd4);
        chk("owner1", 64'(owner_w[0]), 64'h1);
        req_v[0][1] = 1'b0;
        @(negedge clk);
        chk("hex0_F_dp", 64'(hex_w[0][0]), 64'h0e);
        for (int i = 1; i < 6; i++) chk("hexN_F", 64'(hex_w[0][i]), 64'h8e);
        chk("hold_active_mid", 64'(hold_w[0]), 64'h1);

        // Reset in the middle of a hold
        #2 reset = 1'b1;
        #1;
        chk("rst_hold", 64'(hold_w[0]), 64'h0);
        chk("rst_hex", 64'(hex_w[0]), 64'({6{8'hff}}));
        chk("rst_owner", 64'(owner_w[0]), 64'h1);
        #1 reset = 1'b0;
        @(negedge clk);
        req_v[0][1] = 1'b1; data_v[0][1] = 24'habcdef; dp_v[0][1] = 6'h0;
        @(negedge clk);
        chk("post_rst_gnt1", 64'(gnt_w[0][1]), 64'h1);
        req_v[0][1] = 1'b0;

        // Hold 0: both requesters held high alternate
        req_v[1][0] = 1'b1; data_v[1][0] = 24'h111111; dp_v[1][0] = 6'h0;
        req_v[1][1] = 1'b1; data_v[1][1] = 24'h222222; dp_v[1][1] = 6'h0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("rr_seq%0d", j), 64'(gnt_w[1]), 64'(rr_exp[j]));
        end
        req_v[1] = 2'b00;
        repeat (3) @(negedge clk);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                for (int r = 0; r < 2; r++) rand_req(k, r);
        end
        @(negedge clk);
        req_v = '0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
